// File: rtl/pdm_cfg_pkg.sv
// Shared opcodes, FSM encoding and error-bit positions for the PDM config sequencer.
package pdm_cfg_pkg;
  localparam logic [1:0] OP_REG_WR   = 2'b00;
  localparam logic [1:0] OP_COEF_PTR = 2'b01;
  localparam logic [1:0] OP_COEF_DAT = 2'b10;
  localparam logic [1:0] OP_COMMIT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COEF_REQ    = 2'd1,
    COMMIT_WAIT = 2'd2
  } state_t;

  localparam logic [5:0] ERR_CLR_ADDR = 6'h3F;

  localparam int ERR_BAD_ADDR = 0;
  localparam int ERR_OVERRUN  = 1;
  localparam int ERR_TIMEOUT  = 2;
endpackage

// File: rtl/pdm_cfg_shadow_bank.sv
// Shadow/active register pair: writes land in shadow, commit copies the whole bank at once.
module pdm_cfg_shadow_bank
  import pdm_cfg_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [5:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  output logic [NUM_REGS*8-1:0] cfg_active,
  output logic                  cfg_update
);
  logic [NUM_REGS-1:0][7:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      cfg_active <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= commit;
      if (commit) cfg_active <= shadow;
      for (int i = 0; i < NUM_REGS; i++)
        if (wr_en && wr_addr == 6'(i)) shadow[i] <= wr_data;
    end
  end
endmodule

// File: rtl/pdm_cfg_ctrl.sv
// SPI command decoder / commit sequencer for the PDM pitch filter configuration.
// Optional ack watchdog on coefficient writes: define PDM_CFG_ACK_WDT_EN.
module pdm_cfg_ctrl
  import pdm_cfg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int COEF_DEPTH  = 32,
  parameter int ACK_TIMEOUT = 255,
  localparam int COEF_AW    = $clog2(COEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  word_valid,
  input  logic [15:0]           word,
  input  logic                  frame_strobe,
  output logic [NUM_REGS*8-1:0] cfg_active,
  output logic                  cfg_update,
  output logic                  coef_wr_req,
  output logic [COEF_AW-1:0]    coef_wr_addr,
  output logic [11:0]           coef_wr_data,
  input  logic                  coef_wr_ack,
  output logic [2:0]            err_flags,
  output logic                  busy
);
  localparam logic [6:0]         NUM_REGS_W = 7'(NUM_REGS);
  localparam logic [COEF_AW-1:0] PTR_LAST   = COEF_AW'(COEF_DEPTH - 1);

  state_t             state;
  logic [COEF_AW-1:0] ptr;
  logic [2:0]         err;

  logic [1:0] op;
  logic [5:0] reg_addr;
  logic       decode, wr_en, err_clr, bad_addr, overrun, commit, timeout;

  assign op       = word[15:14];
  assign reg_addr = word[13:8];
  assign decode   = word_valid && (state == IDLE);
  assign wr_en    = decode && (op == OP_REG_WR) && ({1'b0, reg_addr} < NUM_REGS_W);
  assign err_clr  = decode && (op == OP_REG_WR) && (reg_addr == ERR_CLR_ADDR);
  assign bad_addr = decode && (op == OP_REG_WR) && !err_clr && !wr_en;
  assign overrun  = word_valid && (state != IDLE);
  // Only a strobe seen while already waiting counts, so one arriving with COMMIT is skipped.
  assign commit   = (state == COMMIT_WAIT) && frame_strobe;

`ifdef PDM_CFG_ACK_WDT_EN
  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] wdt_cnt;
  assign timeout   = (state == COEF_REQ) && !coef_wr_ack && (wdt_cnt == CNT_LAST);
  assign err_flags = err;
`else
  assign timeout   = 1'b0;
  assign err_flags = {1'b0, err[1:0]};
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      err          <= '0;
      coef_wr_req  <= 1'b0;
      coef_wr_addr <= '0;
      coef_wr_data <= '0;
`ifdef PDM_CFG_ACK_WDT_EN
      wdt_cnt      <= '0;
`endif
    end else begin
      // A new error event outranks a clear landing on the same edge.
      err <= (err_clr ? 3'b000 : err) | {timeout, overrun, bad_addr};
      case (state)
        IDLE: if (word_valid) begin
          case (op)
            OP_COEF_PTR: ptr <= word[COEF_AW-1:0];
            OP_COEF_DAT: begin
              state        <= COEF_REQ;
              coef_wr_req  <= 1'b1;
              coef_wr_addr <= ptr;
              coef_wr_data <= word[11:0];
`ifdef PDM_CFG_ACK_WDT_EN
              wdt_cnt      <= '0;
`endif
            end
            OP_COMMIT: state <= COMMIT_WAIT;
            default: ;
          endcase
        end
        COEF_REQ: begin
          if (coef_wr_ack) begin
            coef_wr_req <= 1'b0;
            ptr         <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            state       <= IDLE;
          end else if (timeout) begin
            coef_wr_req <= 1'b0;
            state       <= IDLE;
          end
`ifdef PDM_CFG_ACK_WDT_EN
          else wdt_cnt <= wdt_cnt + 1'b1;
`endif
        end
        COMMIT_WAIT: if (frame_strobe) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pdm_cfg_shadow_bank #(.NUM_REGS(NUM_REGS)) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (reg_addr),
    .wr_data    (word[7:0]),
    .commit     (commit),
    .cfg_active (cfg_active),
    .cfg_update (cfg_update)
  );
endmodule

// File: tb/tb_pdm_cfg_ctrl.sv
// Directed bench for pdm_cfg_ctrl: register table, commit timing, coef handshake, errors, reset.
module tb_pdm_cfg_ctrl;
  localparam int NUM_REGS    = 8;
  localparam int COEF_DEPTH  = 32;
  localparam int ACK_TIMEOUT = 4;
  localparam int AW          = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  word_valid = 1'b0;
  logic [15:0]           word = '0;
  logic                  frame_strobe = 1'b0;
  logic [NUM_REGS*8-1:0] cfg_active;
  logic                  cfg_update;
  logic                  coef_wr_req;
  logic [AW-1:0]         coef_wr_addr;
  logic [11:0]           coef_wr_data;
  logic                  coef_wr_ack = 1'b0;
  logic [2:0]            err_flags;
  logic                  busy;

  pdm_cfg_ctrl #(.NUM_REGS(NUM_REGS), .COEF_DEPTH(COEF_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word(word), .frame_strobe(frame_strobe),
    .cfg_active(cfg_active), .cfg_update(cfg_update), .coef_wr_req(coef_wr_req),
    .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data), .coef_wr_ack(coef_wr_ack),
    .err_flags(err_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] model[NUM_REGS];

  function automatic logic [63:0] model_bank();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[i*8 +: 8] = model[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    word_valid = 1'b1;
    word       = w;
    tick();
    word_valid = 1'b0;
    word       = '0;
  endtask

  task automatic strobe_and_check(input string nm);
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    chk({nm, "_active"}, cfg_active, model_bank());
    chk({nm, "_update"}, {63'b0, cfg_update}, 64'd1);
    tick();
    chk({nm, "_update_end"}, {63'b0, cfg_update}, 64'd0);
    chk({nm, "_idle"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0011, 3'b000};
    vecs[1] = '{16'h0122, 3'b000};
    vecs[2] = '{16'h0255, 3'b000};
    vecs[3] = '{16'h0780, 3'b000};
    vecs[4] = '{16'h0933, 3'b001};
    vecs[5] = '{16'h3F00, 3'b000};
    vecs[6] = '{16'h0144, 3'b000};
    vecs[7] = '{16'h4005, 3'b000};
    vecs[8] = '{16'h3E01, 3'b001};
    vecs[9] = '{16'h3FFF, 3'b000};
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;

    #12;
    chk("rst_active", cfg_active, 64'h0);
    chk("rst_outs", {52'b0, coef_wr_req, cfg_update, busy, err_flags, coef_wr_addr}, 64'h0);
    chk("rst_data", {52'b0, coef_wr_data}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Register writes only touch shadow; active stays 0 until a commit.
    for (int i = 0; i < 10; i++) begin
      send_word(vecs[i].word);
      if (vecs[i].word[15:14] == 2'b00 && vecs[i].word[13:8] < 6'(NUM_REGS))
        model[vecs[i].word[10:8]] = vecs[i].word[7:0];
      chk($sformatf("vec%0d_err", i), {61'b0, err_flags}, {61'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_active", i), cfg_active, 64'h0);
    end

    send_word(16'hC000);
    chk("commit_busy", {63'b0, busy}, 64'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("commit_wait_noupd", {63'b0, cfg_update}, 64'd0);
    chk("commit_wait_active", cfg_active, 64'h0);
    strobe_and_check("commit1");
    chk("commit1_reg2", {56'b0, cfg_active[23:16]}, 64'h55);

    // Coef write at last index, acked on the third req cycle, pointer wraps.
    send_word(16'h401F);
    send_word(16'h8ABC);
    chk("coef_req1", {63'b0, coef_wr_req}, 64'd1);
    chk("coef_addr", {59'b0, coef_wr_addr}, 64'd31);
    chk("coef_data", {52'b0, coef_wr_data}, 64'hABC);
    tick();
    chk("coef_req2", {63'b0, coef_wr_req}, 64'd1);
    tick();
    chk("coef_req3", {63'b0, coef_wr_req}, 64'd1);
    coef_wr_ack = 1'b1;
    tick();
    coef_wr_ack = 1'b0;
    chk("coef_req_drop", {63'b0, coef_wr_req}, 64'd0);
    chk("coef_idle", {63'b0, busy}, 64'd0);
    send_word(16'h8123);
    chk("coef_wrap_addr", {59'b0, coef_wr_addr}, 64'd0);
    coef_wr_ack = 1'b1;
    tick();
    coef_wr_ack = 1'b0;
    chk("coef_fast_ack", {63'b0, coef_wr_req}, 64'd0);

    // Overrun while a request is pending; then clear flags.
    send_word(16'h8001);
    chk("ovr_addr", {59'b0, coef_wr_addr}, 64'd1);
    send_word(16'h0277);
    chk("ovr_err", {61'b0, err_flags}, 64'b010);
    chk("ovr_req_held", {63'b0, coef_wr_req}, 64'd1);
    chk("ovr_addr_held", {59'b0, coef_wr_addr}, 64'd1);
    coef_wr_ack = 1'b1;
    tick();
    coef_wr_ack = 1'b0;
    send_word(16'h3F00);
    chk("clr_err", {61'b0, err_flags}, 64'b000);

    // Bad address, then commit whose coincident strobe is ignored.
    send_word(16'h0912);
    chk("bad_err", {61'b0, err_flags}, 64'b001);
    send_word(16'h0566);
    model[5] = 8'h66;
    word_valid = 1'b1; word = 16'hC000; frame_strobe = 1'b1;
    tick();
    word_valid = 1'b0; word = '0; frame_strobe = 1'b0;
    chk("coinc_busy", {63'b0, busy}, 64'd1);
    chk("coinc_noupd", {63'b0, cfg_update}, 64'd0);
    tick();
    chk("coinc_noupd2", {63'b0, cfg_update}, 64'd0);
    chk("coinc_active_old", {56'b0, cfg_active[47:40]}, 64'h00);
    strobe_and_check("commit2");
    send_word(16'h3F00);

`ifdef PDM_CFG_ACK_WDT_EN
    send_word(16'h80AA);
    chk("wdt_req1", {63'b0, coef_wr_req}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wdt_req%0d", k + 2), {63'b0, coef_wr_req}, 64'd1);
    end
    tick();
    chk("wdt_drop", {63'b0, coef_wr_req}, 64'd0);
    chk("wdt_err", {61'b0, err_flags}, 64'b100);
    chk("wdt_idle", {63'b0, busy}, 64'd0);
    send_word(16'h8055);
    chk("wdt_ptr_same", {59'b0, coef_wr_addr}, 64'd2);
    coef_wr_ack = 1'b1;
    tick();
    coef_wr_ack = 1'b0;
`else
    send_word(16'h80AA);
    for (int k = 0; k < 20; k++) tick();
    chk("nowdt_req", {63'b0, coef_wr_req}, 64'd1);
    chk("nowdt_err", {61'b0, err_flags}, 64'b000);
    chk("nowdt_addr", {59'b0, coef_wr_addr}, 64'd2);
    coef_wr_ack = 1'b1;
    tick();
    coef_wr_ack = 1'b0;
    chk("nowdt_drop", {63'b0, coef_wr_req}, 64'd0);
`endif

    // Asynchronous reset during COMMIT_WAIT, then during COEF_REQ.
    send_word(16'h0099);
    send_word(16'hC000);
    chk("rst_cw_busy", {63'b0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cw_active", cfg_active, 64'h0);
    chk("rst_cw_busy0", {63'b0, busy}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    frame_strobe = 1'b1;
    tick();
    frame_strobe = 1'b0;
    chk("rst_cw_noupd", {63'b0, cfg_update}, 64'd0);
    chk("rst_cw_active2", cfg_active, 64'h0);
    send_word(16'h8123);
    chk("rst_cr_req", {63'b0, coef_wr_req}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cr_req0", {63'b0, coef_wr_req}, 64'd0);
    chk("rst_cr_outs", {49'b0, coef_wr_data, err_flags}, 64'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_cr_idle", {62'b0, busy, coef_wr_req}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
